// File: rtl/quad_dec_pkg.sv
// Shared constants, types and helpers for the quadrature decoder with velocity capture.
package quad_dec_pkg;

    // Register map (16-bit words, 3-bit address)
    localparam logic [2:0] ADDR_STATUS = 3'd0;
    localparam logic [2:0] ADDR_CTRL   = 3'd1;
    localparam logic [2:0] ADDR_SNAP_L = 3'd2;
    localparam logic [2:0] ADDR_SNAP_H = 3'd3;
    localparam logic [2:0] ADDR_VEL    = 3'd4;
    localparam logic [2:0] ADDR_FILT   = 3'd5;

    // Control register bit positions
    localparam int CTRL_IRQ_EN  = 0;
    localparam int CTRL_ENABLE  = 1;
    localparam int CTRL_CLR_POS = 2;
    localparam int CTRL_INVERT  = 3;

    // Status register bit positions
    localparam int STAT_CAP = 0;
    localparam int STAT_ERR = 1;
    localparam int STAT_DIR = 2;

    // Velocity saturation limits (signed 16-bit range held in 32 bits)
    localparam logic signed [31:0] VEL_MAX = 32'sd32767;
    localparam logic signed [31:0] VEL_MIN = -32'sd32768;

    // Classification of one filtered {A,B} transition
    typedef enum logic [1:0] {
        STEP_NONE    = 2'd0,
        STEP_FWD     = 2'd1,
        STEP_REV     = 2'd2,
        STEP_ILLEGAL = 2'd3
    } step_t;

    // Forward order is 00 -> 01 -> 11 -> 10 -> 00; a two-bit jump is illegal.
    function automatic step_t decode_step(input logic [1:0] prev_ab, input logic [1:0] cur_ab);
        step_t res;
        res = STEP_NONE;
        case ({prev_ab, cur_ab})
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: res = STEP_FWD;
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: res = STEP_REV;
            4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: res = STEP_ILLEGAL;
            default:                                res = STEP_NONE;
        endcase
        return res;
    endfunction

    // Clamp a wrapped 32-bit position delta to the signed 16-bit velocity range.
    function automatic logic [15:0] sat_vel(input logic [31:0] delta);
        logic signed [31:0] d;
        logic [15:0]        res;
        d = signed'(delta);
        if (d > VEL_MAX) begin
            res = 16'h7FFF;
        end else if (d < VEL_MIN) begin
            res = 16'h8000;
        end else begin
            res = delta[15:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/quad_dec_filter.sv
// One encoder channel: 2-FF synchronizer followed by a length-programmable glitch filter.
module quad_dec_filter #(
    parameter int FILT_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              din,
    input  logic [FILT_W-1:0] filt_len,
    output logic              filt_out
);

    logic              sync1_r;
    logic              sync2_r;
    logic              filt_r;
    logic [FILT_W-1:0] cnt_r;

    // Bring the asynchronous input into the clk domain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= din;
            sync2_r <= sync1_r;
        end
    end

    // Accept a new level only after it differs for filt_len+1 consecutive clocks;
    // a return to the filtered level restarts the count. Comparing with >= lets a
    // shortened filter length take effect on a count already in progress.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt_r <= 1'b0;
            cnt_r  <= '0;
        end else if (sync2_r == filt_r) begin
            filt_r <= filt_r;
            cnt_r  <= '0;
        end else if (cnt_r >= filt_len) begin
            filt_r <= sync2_r;
            cnt_r  <= '0;
        end else begin
            filt_r <= filt_r;
            cnt_r  <= cnt_r + {{(FILT_W-1){1'b0}}, 1'b1};
        end
    end

    assign filt_out = filt_r;

endmodule

// File: rtl/quad_dec_velocity.sv
// Avalon-MM quadrature decoder: 32-bit position counter plus signed 16-bit velocity
// captured on each rising edge of the timer's sample_tick.
module quad_dec_velocity
    import quad_dec_pkg::*;
#(
    parameter int FILT_W   = 8,
    parameter int FILT_RST = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    output logic        irq,
    input  logic        enc_a,
    input  logic        enc_b,
    input  logic        sample_tick
);

    // Register state
    logic [FILT_W-1:0] filt_len_r;
    logic              irq_en_r;
    logic              enable_r;
    logic              invert_r;
    logic              cap_r;
    logic              err_r;
    logic              dir_r;
    logic [31:0]       pos_r;
    logic [31:0]       last_pos_r;
    logic [31:0]       snap_r;
    logic [15:0]       vel_r;
    logic [1:0]        prev_ab_r;
    logic              tick_sync1_r;
    logic              tick_sync2_r;
    logic              tick_dly_r;
    logic [15:0]       readdata_r;

    // Combinational decode
    logic              a_filt_s;
    logic              b_filt_s;
    logic [1:0]        cur_ab_s;
    step_t             step_s;
    logic              count_s;
    logic              rev_s;
    logic [31:0]       pos_next_s;
    logic              tick_event_s;
    logic              wr_s;
    logic              status_wr_s;
    logic              ctrl_wr_s;
    logic              snap_wr_s;
    logic              filt_wr_s;
    logic              clear_pos_s;
    logic [15:0]       filt_rd_s;
    logic [15:0]       rd_mux_s;
    logic              unused_wdata_s;

    quad_dec_filter #(.FILT_W(FILT_W)) u_filt_a (
        .clk      (clk),
        .reset_n  (reset_n),
        .din      (enc_a),
        .filt_len (filt_len_r),
        .filt_out (a_filt_s)
    );

    quad_dec_filter #(.FILT_W(FILT_W)) u_filt_b (
        .clk      (clk),
        .reset_n  (reset_n),
        .din      (enc_b),
        .filt_len (filt_len_r),
        .filt_out (b_filt_s)
    );

    // Upper writedata bits beyond the filter length carry no function.
    assign unused_wdata_s = ^writedata;

    // Bus write decode.
    always_comb begin
        wr_s        = chipselect & ~write_n;
        status_wr_s = wr_s && (address == ADDR_STATUS);
        ctrl_wr_s   = wr_s && (address == ADDR_CTRL);
        snap_wr_s   = wr_s && ((address == ADDR_SNAP_L) || (address == ADDR_SNAP_H));
        filt_wr_s   = wr_s && (address == ADDR_FILT);
        clear_pos_s = ctrl_wr_s && writedata[CTRL_CLR_POS];
    end

    // Quadrature step decode, direction and tick edge detection.
    always_comb begin
        cur_ab_s     = {a_filt_s, b_filt_s};
        step_s       = decode_step(prev_ab_r, cur_ab_s);
        count_s      = enable_r && ((step_s == STEP_FWD) || (step_s == STEP_REV));
        rev_s        = (step_s == STEP_REV) ^ invert_r;
        if (rev_s) begin
            pos_next_s = pos_r - 32'd1;
        end else begin
            pos_next_s = pos_r + 32'd1;
        end
        tick_event_s = tick_sync2_r & ~tick_dly_r;
    end

    // Synchronize sample_tick and keep a delayed copy for rising-edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_sync1_r <= 1'b0;
            tick_sync2_r <= 1'b0;
            tick_dly_r   <= 1'b0;
        end else begin
            tick_sync1_r <= sample_tick;
            tick_sync2_r <= tick_sync1_r;
            tick_dly_r   <= tick_sync2_r;
        end
    end

    // Remember the previous filtered {A,B} for transition decoding.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_ab_r <= 2'b00;
        end else begin
            prev_ab_r <= cur_ab_s;
        end
    end

    // Position counter; a clear request overrides a step in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pos_r <= 32'd0;
        end else if (clear_pos_s) begin
            pos_r <= 32'd0;
        end else if (count_s) begin
            pos_r <= pos_next_s;
        end else begin
            pos_r <= pos_r;
        end
    end

    // Velocity capture: delta from the pre-clear position, then rebase last_pos.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vel_r      <= 16'd0;
            last_pos_r <= 32'd0;
        end else begin
            if (tick_event_s) begin
                vel_r <= sat_vel(pos_r - last_pos_r);
            end else begin
                vel_r <= vel_r;
            end
            if (clear_pos_s) begin
                last_pos_r <= 32'd0;
            end else if (tick_event_s) begin
                last_pos_r <= pos_r;
            end else begin
                last_pos_r <= last_pos_r;
            end
        end
    end

    // Status flags: set events win over a simultaneous status write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cap_r <= 1'b0;
            err_r <= 1'b0;
            dir_r <= 1'b0;
        end else begin
            if (tick_event_s) begin
                cap_r <= 1'b1;
            end else if (status_wr_s) begin
                cap_r <= 1'b0;
            end else begin
                cap_r <= cap_r;
            end
            if (step_s == STEP_ILLEGAL) begin
                err_r <= 1'b1;
            end else if (status_wr_s) begin
                err_r <= 1'b0;
            end else begin
                err_r <= err_r;
            end
            if (count_s) begin
                dir_r <= rev_s;
            end else begin
                dir_r <= dir_r;
            end
        end
    end

    // Control bits and filter length; the clear_pos bit is a strobe and is not stored.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_en_r   <= 1'b0;
            enable_r   <= 1'b0;
            invert_r   <= 1'b0;
            filt_len_r <= FILT_W'(FILT_RST);
        end else begin
            if (ctrl_wr_s) begin
                irq_en_r <= writedata[CTRL_IRQ_EN];
                enable_r <= writedata[CTRL_ENABLE];
                invert_r <= writedata[CTRL_INVERT];
            end else begin
                irq_en_r <= irq_en_r;
                enable_r <= enable_r;
                invert_r <= invert_r;
            end
            if (filt_wr_s) begin
                filt_len_r <= writedata[FILT_W-1:0];
            end else begin
                filt_len_r <= filt_len_r;
            end
        end
    end

    // Snapshot the live position on any write to either snapshot half.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            snap_r <= 32'd0;
        end else if (snap_wr_s) begin
            snap_r <= pos_r;
        end else begin
            snap_r <= snap_r;
        end
    end

    // Read data multiplexer; unused bits and addresses read as zero.
    always_comb begin
        filt_rd_s               = 16'd0;
        filt_rd_s[FILT_W-1:0]   = filt_len_r;
        rd_mux_s                = 16'd0;
        case (address)
            ADDR_STATUS: rd_mux_s = {13'd0, dir_r, err_r, cap_r};
            ADDR_CTRL:   rd_mux_s = {12'd0, invert_r, 1'b0, enable_r, irq_en_r};
            ADDR_SNAP_L: rd_mux_s = snap_r[15:0];
            ADDR_SNAP_H: rd_mux_s = snap_r[31:16];
            ADDR_VEL:    rd_mux_s = vel_r;
            ADDR_FILT:   rd_mux_s = filt_rd_s;
            default:     rd_mux_s = 16'd0;
        endcase
    end

    // Registered read data, one cycle after the selected address.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata_r <= 16'd0;
        end else if (chipselect) begin
            readdata_r <= rd_mux_s;
        end else begin
            readdata_r <= readdata_r;
        end
    end

    assign readdata = readdata_r;
    assign irq      = cap_r & irq_en_r;

endmodule
